// File: rtl/hpc_rand_source.sv
// Fresh-randomness source for first-order HPC gadgets: seeded 31-bit Fibonacci LFSR with warm-up,
// handing out RAND_WIDTH new bits per consumed cycle under a valid/enable handshake.
module hpc_rand_source #(
  parameter int unsigned RAND_WIDTH    = 2,
  parameter int unsigned WARMUP_CYCLES = 32,
  parameter logic [30:0] DEFAULT_SEED  = 31'h5A5A_1234
) (
  input  logic                  clock_0,
  input  logic                  reset_0,
  input  logic [30:0]           seed_i,
  input  logic                  seed_load_i,
  input  logic                  rand_en_i,
  output logic [RAND_WIDTH-1:0] rand_o,
  output logic                  rand_valid_o,
  output logic                  lfsr_zero_o
);

  localparam int unsigned CNT_W = (WARMUP_CYCLES == 0) ? 1 : $clog2(WARMUP_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WARMUP_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    WARMUP,
    RUN
  } state_e;

  state_e           state_q, state_d;
  logic [30:0]      lfsr_q, lfsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             zero_q, zero_d;

  logic             fault_now;
  logic             freeze;
  logic [30:0]      seed_eff;
  logic [30:0]      lfsr_adv;

  // RAND_WIDTH single steps unrolled so every bit of rand_o is freshly shifted in.
  function automatic logic [30:0] lfsr_advance(input logic [30:0] s);
    logic [30:0] t;
    t = s;
    for (int unsigned i = 0; i < RAND_WIDTH; i++) begin
      t = {t[29:0], t[30] ^ t[27]};
    end
    return t;
  endfunction

  always_comb begin
    fault_now = (state_q != IDLE) && (lfsr_q == '0);
    freeze    = zero_q || fault_now;
    zero_d    = freeze;
    seed_eff  = (seed_i == '0) ? DEFAULT_SEED : seed_i;
    lfsr_adv  = lfsr_advance(lfsr_q);
  end

  always_ff @(posedge clock_0) begin
    if (reset_0) begin
      state_q <= IDLE;
      lfsr_q  <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!freeze) begin
      if (seed_load_i) begin
        state_d = (WARMUP_CYCLES == 0) ? RUN : WARMUP;
      end else if (state_q == WARMUP && cnt_q == '0) begin
        state_d = RUN;
      end
    end
  end

  // Warm-up advances only while the counter is non-zero, giving exactly WARMUP_CYCLES advances.
  always_comb begin
    lfsr_d = lfsr_q;
    cnt_d  = cnt_q;
    if (!freeze) begin
      if (seed_load_i) begin
        lfsr_d = seed_eff;
        cnt_d  = CNT_INIT;
      end else begin
        case (state_q)
          WARMUP: begin
            if (cnt_q != '0) begin
              lfsr_d = lfsr_adv;
              cnt_d  = cnt_q - CNT_W'(1);
            end
          end
          RUN: begin
            if (rand_en_i) lfsr_d = lfsr_adv;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rand_o       = lfsr_q[RAND_WIDTH-1:0];
    rand_valid_o = (state_q == RUN) && !zero_q && !fault_now;
    lfsr_zero_o  = zero_q;
  end

endmodule

// File: tb/tb_hpc_rand_source.sv
// Scoreboard bench for hpc_rand_source: stimulus pushes predicted rand_o values, a monitor checks
// every consumption; directed checks cover reset, latency, reseed, zero seed and the zero fault.
module tb_hpc_rand_source;

  localparam logic [30:0] DEF_SEED = 31'h5A5A_1234;

  logic        clk = 1'b0;
  logic        rst;
  logic [30:0] seed, seed0;
  logic        load, load0, en, en0;
  logic [1:0]  rnd, rnd0;
  logic        valid, valid0, zflag, zflag0;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [1:0]  exp_q[$];
  logic [30:0] m;

  always #5 clk = ~clk;

  hpc_rand_source dut (
    .clock_0(clk), .reset_0(rst), .seed_i(seed), .seed_load_i(load), .rand_en_i(en),
    .rand_o(rnd), .rand_valid_o(valid), .lfsr_zero_o(zflag)
  );

  hpc_rand_source #(.RAND_WIDTH(2), .WARMUP_CYCLES(0)) dut0 (
    .clock_0(clk), .reset_0(rst), .seed_i(seed0), .seed_load_i(load0), .rand_en_i(en0),
    .rand_o(rnd0), .rand_valid_o(valid0), .lfsr_zero_o(zflag0)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: one consumption shifts in two bits, each the XOR of bits 30 and 27.
  function automatic logic [30:0] model_adv(input logic [30:0] s);
    int unsigned r;
    r = int'(s);
    for (int k = 0; k < 2; k++) begin
      r = ((r << 1) | (((r >> 30) ^ (r >> 27)) & 1)) & 32'h7FFF_FFFF;
    end
    return r[30:0];
  endfunction

  always @(negedge clk) begin
    if (!rst && valid && en && !load) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_unexpected: got %0h expected none", rnd);
      end else begin
        chk("sb_rand", {62'd0, rnd}, {62'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [30:0] s);
    seed = s;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!valid && n < 200) begin
      tick();
      n++;
    end
    chk("warmup_len", n, 33);
  endtask

  task automatic warm_model(input logic [30:0] s);
    m = (s == '0) ? DEF_SEED : s;
    repeat (32) m = model_adv(m);
  endtask

  task automatic stream(input int n, input bit random_en);
    for (int i = 0; i < n; i++) begin
      en = random_en ? 1'($urandom_range(0, 1)) : 1'b1;
      if (en) begin
        exp_q.push_back(m[1:0]);
        m = model_adv(m);
      end
      tick();
    end
    en = 1'b0;
    chk("lfsr_track", dut.lfsr_q, m);
  endtask

  initial begin
    logic [30:0] s;
    rst = 1'b1; load = 1'b1; load0 = 1'b1; en = 1'b1; en0 = 1'b1;
    seed = 31'h1; seed0 = 31'h1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_valid", valid, 0);
      chk("rst_rand", rnd, 0);
      chk("rst_zero", zflag, 0);
      chk("rst_valid0", valid0, 0);
    end
    rst = 1'b0; load = 1'b0; load0 = 1'b0; en = 1'b0; en0 = 1'b0;
    tick();
    chk("idle_valid", valid, 0);

    // zero warm-up instance
    seed0 = 31'h1; load0 = 1'b1;
    tick();
    load0 = 1'b0;
    chk("w0_valid", valid0, 1);
    chk("w0_rand_seed", rnd0, 2'b01);
    en0 = 1'b1;
    tick();
    en0 = 1'b0;
    chk("w0_lfsr_adv", dut0.lfsr_q, 31'h4);
    chk("w0_rand_adv", rnd0, 2'b00);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("w0_hold", dut0.lfsr_q, 31'h4);
    end

    // default params, seed 1
    do_load(31'h1);
    chk("load_valid_low", valid, 0);
    wait_valid();
    warm_model(31'h1);
    chk("warm_lfsr", dut.lfsr_q, m);
    stream(1000, 1'b0);
    stream(300, 1'b1);

    // zero seed substitutes DEFAULT_SEED
    do_load(31'h0);
    chk("zero_seed_lfsr", dut.lfsr_q, DEF_SEED);
    wait_valid();
    warm_model(31'h0);
    stream(200, 1'b1);

    // reseed mid-run with a simultaneous consume
    s = 31'($urandom) | 31'h1;
    seed = s; load = 1'b1; en = 1'b1;
    tick();
    load = 1'b0; en = 1'b0;
    chk("reseed_valid_drop", valid, 0);
    chk("reseed_no_adv", dut.lfsr_q, s);
    wait_valid();
    warm_model(s);
    stream(100, 1'b1);

    // reset during warm-up
    do_load(31'h1234_5678);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midwarm_rst_valid", valid, 0);
    chk("midwarm_rst_rand", rnd, 0);
    chk("midwarm_rst_lfsr", dut.lfsr_q, 0);
    chk("midwarm_rst_zero", zflag, 0);

    // zero-state fault is sticky until reset
    do_load(31'h0BAD_F00D);
    wait_valid();
    force dut.lfsr_q = 31'h0;
    tick();
    release dut.lfsr_q;
    chk("fault_flag", zflag, 1);
    chk("fault_valid", valid, 0);
    do_load(31'h0000_0777);
    repeat (40) tick();
    chk("fault_sticky_flag", zflag, 1);
    chk("fault_sticky_valid", valid, 0);
    chk("fault_frozen_lfsr", dut.lfsr_q, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("fault_clear", zflag, 0);

    chk("sb_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
